// File: rtl/mem_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_readout_sequencer
// Description : Walks the non-empty memory blocks of an event in fixed priority,
//               issuing one read address per cycle under a per-event cycle budget.
//               Optional SEQ_TRUNC_CNT_EN adds a saturating truncated-entry counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_readout_sequencer #(
    parameter int NBLK    = 20,
    parameter int ADDR_W  = 6,
    parameter int BX_W    = 3,
    parameter int SEL_W   = 5,
    parameter int RD_LAT  = 2,
    parameter int MAX_CYC = 108
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BX_W-1:0]        bx,
    input  logic [NBLK*ADDR_W-1:0] nent,
    input  logic                   halt,
    output logic                   rd_en,
    output logic [BX_W+ADDR_W-1:0] read_add,
    output logic [SEL_W-1:0]       sel,
    output logic                   dat_valid,
    output logic [SEL_W-1:0]       dat_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   trunc
`ifdef SEQ_TRUNC_CNT_EN
    ,
    output logic [15:0]            trunc_cnt
`endif
);

    localparam int CYC_W = $clog2(MAX_CYC + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t             r_state;
    logic [NBLK-1:0]    r_mask;
    logic [ADDR_W-1:0]  r_cnt [NBLK];
    logic [BX_W-1:0]    r_bx;
    logic [ADDR_W-1:0]  r_idx;
    logic [CYC_W-1:0]   r_cyc;

    logic [NBLK-1:0]    w_new_mask;
    logic [SEL_W-1:0]   w_cur;
    logic [ADDR_W-1:0]  w_cur_cnt;
    logic               w_last;
    logic               w_end;
    logic               w_issue;
    logic               w_expire;

    // Lowest pending bit wins: scan downwards so block 0 is assigned last.
    always_comb begin
        w_cur     = '0;
        w_cur_cnt = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_cur     = SEL_W'(i);
                w_cur_cnt = r_cnt[i];
            end
        end
    end

    always_comb begin
        w_new_mask = '0;
        for (int i = 0; i < NBLK; i++) begin
            w_new_mask[i] = (nent[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    assign w_last   = (r_idx == w_cur_cnt - 1'b1);
    assign w_end    = (r_state == S_READ) && ((r_mask == '0) || (r_cyc == CYC_W'(MAX_CYC)));
    assign w_issue  = !start && (r_state == S_READ) && !w_end && !halt;
    assign w_expire = !start && w_end && (|r_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_bx     <= '0;
            r_idx    <= '0;
            r_cyc    <= '0;
            for (int i = 0; i < NBLK; i++) begin
                r_cnt[i] <= '0;
            end
            rd_en    <= 1'b0;
            read_add <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            trunc    <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            trunc <= 1'b0;
            if (start) begin
                // A still-running event is dropped; one that ends this cycle still reports done.
                r_state <= S_READ;
                busy    <= 1'b1;
                r_mask  <= w_new_mask;
                r_bx    <= bx;
                r_idx   <= '0;
                r_cyc   <= '0;
                for (int i = 0; i < NBLK; i++) begin
                    r_cnt[i] <= nent[i*ADDR_W +: ADDR_W];
                end
                if (w_end) begin
                    done  <= 1'b1;
                    trunc <= |r_mask;
                end
            end else if (r_state == S_READ) begin
                r_cyc <= r_cyc + 1'b1;
                if (w_end) begin
                    done    <= 1'b1;
                    trunc   <= |r_mask;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                    r_mask  <= '0;
                end else if (!halt) begin
                    rd_en    <= 1'b1;
                    read_add <= {r_bx, r_idx};
                    sel      <= w_cur;
                    if (w_last) begin
                        r_mask[w_cur] <= 1'b0;
                        r_idx         <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            end
        end
    end

    // Pure shift of the issue strobe/select to line up with memory read data.
    logic [RD_LAT-1:0] r_vpipe;
    logic [SEL_W-1:0]  r_spipe [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vpipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_spipe[i] <= '0;
            end
        end else begin
            r_vpipe[0] <= rd_en;
            r_spipe[0] <= sel;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_spipe[i] <= r_spipe[i-1];
            end
        end
    end

    assign dat_valid = r_vpipe[RD_LAT-1];
    assign dat_sel   = r_spipe[RD_LAT-1];

`ifdef SEQ_TRUNC_CNT_EN
    localparam int REM_W = ADDR_W + 6;

    logic [REM_W-1:0] r_remain;
    logic [REM_W-1:0] w_total;
    logic [31:0]      w_tc_sum;
    logic [15:0]      w_tc_sat;

    always_comb begin
        w_total = '0;
        for (int i = 0; i < NBLK; i++) begin
            w_total = w_total + REM_W'(nent[i*ADDR_W +: ADDR_W]);
        end
    end

    assign w_tc_sum = 32'(trunc_cnt) + 32'(r_remain);
    assign w_tc_sat = (w_tc_sum > 32'h0000_FFFF) ? 16'hFFFF : w_tc_sum[15:0];

    // r_remain is zero whenever no event is live, so adding it on every start is safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remain  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (start) begin
                r_remain <= w_total;
            end else if (w_expire) begin
                r_remain <= '0;
            end else if (w_issue) begin
                r_remain <= r_remain - 1'b1;
            end
            if (start || w_expire) begin
                trunc_cnt <= w_tc_sat;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_readout_sequencer
// Description : Directed and random stimulus against a queue-based readout model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_readout_sequencer;

    localparam int NBLK    = 20;
    localparam int ADDR_W  = 6;
    localparam int BX_W    = 3;
    localparam int SEL_W   = 5;
    localparam int RD_LAT  = 2;
    localparam int MAX_CYC = 108;
    localparam int NW      = NBLK * ADDR_W;
    localparam int AW      = BX_W + ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [BX_W-1:0]   bx;
    logic [NW-1:0]     nent;
    logic              halt;
    logic              rd_en;
    logic [AW-1:0]     read_add;
    logic [SEL_W-1:0]  sel;
    logic              dat_valid;
    logic [SEL_W-1:0]  dat_sel;
    logic              busy;
    logic              done;
    logic              trunc;
`ifdef SEQ_TRUNC_CNT_EN
    logic [15:0]       trunc_cnt;
`endif

    mem_readout_sequencer #(
        .NBLK    (NBLK),
        .ADDR_W  (ADDR_W),
        .BX_W    (BX_W),
        .SEL_W   (SEL_W),
        .RD_LAT  (RD_LAT),
        .MAX_CYC (MAX_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bx        (bx),
        .nent      (nent),
        .halt      (halt),
        .rd_en     (rd_en),
        .read_add  (read_add),
        .sel       (sel),
        .dat_valid (dat_valid),
        .dat_sel   (dat_sel),
        .busy      (busy),
        .done      (done),
        .trunc     (trunc)
`ifdef SEQ_TRUNC_CNT_EN
        ,
        .trunc_cnt (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEL_W-1:0] s;
        logic [AW-1:0]    a;
    } rd_t;

    int n_checks = 0;
    int n_fail   = 0;

    rd_t              q [$];
    logic             m_act, m_busy, m_rd, m_done, m_trunc;
    logic [SEL_W-1:0] m_sel;
    logic [AW-1:0]    m_add;
    logic             m_dv [RD_LAT];
    logic [SEL_W-1:0] m_ds [RD_LAT];
    int               m_cyc, m_tc;
    int               cyc_no, start_cyc, done_cyc, n_reads, n_dones, n_truncs;
    bit               rand_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] put(input logic [NW-1:0] v, input int b, input int c);
        logic [NW-1:0] r;
        r = v;
        r[b*ADDR_W +: ADDR_W] = ADDR_W'(c);
        return r;
    endfunction

    // Reference: an event is just the ordered list of reads it owes, drained one per free cycle.
    task automatic model_update();
        cyc_no++;
        if (reset) begin
            q.delete();
            m_act = 0; m_busy = 0; m_rd = 0; m_done = 0; m_trunc = 0;
            m_sel = '0; m_add = '0; m_cyc = 0; m_tc = 0;
            for (int i = 0; i < RD_LAT; i++) begin
                m_dv[i] = 0;
                m_ds[i] = '0;
            end
            return;
        end
        for (int i = RD_LAT - 1; i > 0; i--) begin
            m_dv[i] = m_dv[i-1];
            m_ds[i] = m_ds[i-1];
        end
        m_dv[0] = m_rd;
        m_ds[0] = m_sel;
        m_rd = 0; m_done = 0; m_trunc = 0;
        if (start) begin
            start_cyc = cyc_no;
            if (m_act && (q.size() == 0 || m_cyc == MAX_CYC)) begin
                m_done  = 1;
                m_trunc = (q.size() != 0);
            end
            m_tc = (m_tc + q.size() > 65535) ? 65535 : m_tc + q.size();
            q.delete();
            for (int b = 0; b < NBLK; b++) begin
                int c;
                c = int'(nent[b*ADDR_W +: ADDR_W]);
                for (int e = 0; e < c; e++) begin
                    rd_t r;
                    r.s = SEL_W'(b);
                    r.a = {bx, ADDR_W'(e)};
                    q.push_back(r);
                end
            end
            m_act = 1; m_busy = 1; m_cyc = 0;
        end else if (m_act) begin
            if (q.size() == 0) begin
                m_done = 1; m_act = 0; m_busy = 0;
            end else if (m_cyc == MAX_CYC) begin
                m_done = 1; m_trunc = 1; m_act = 0; m_busy = 0;
                m_tc = (m_tc + q.size() > 65535) ? 65535 : m_tc + q.size();
                q.delete();
            end else if (!halt) begin
                rd_t r;
                r = q.pop_front();
                m_rd = 1; m_sel = r.s; m_add = r.a;
            end
            m_cyc++;
        end
    endtask

    task automatic compare();
        chk("rd_en", rd_en, m_rd);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("trunc", trunc, m_trunc);
        chk("dat_valid", dat_valid, m_dv[RD_LAT-1]);
        if (m_rd) begin
            chk("read_add", read_add, m_add);
            chk("sel", sel, m_sel);
        end
        if (m_dv[RD_LAT-1]) chk("dat_sel", dat_sel, m_ds[RD_LAT-1]);
`ifdef SEQ_TRUNC_CNT_EN
        chk("trunc_cnt", trunc_cnt, m_tc);
`endif
        if (rd_en) n_reads++;
        if (done) begin
            n_dones++;
            done_cyc = cyc_no;
        end
        if (trunc) n_truncs++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
        @(negedge clk);
        if (rand_halt) halt = ($urandom % 5 == 0);
    endtask

    task automatic do_start(input logic [NW-1:0] n, input logic [BX_W-1:0] b);
        start = 1; nent = n; bx = b;
        step();
        start = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    initial begin
        logic [NW-1:0] n;
        int r0, d0, t0, tc0;
        reset = 1; start = 0; bx = '0; nent = '0; halt = 0; rand_halt = 0;
        cyc_no = 0; start_cyc = 0; done_cyc = 0; n_reads = 0; n_dones = 0; n_truncs = 0;
        m_act = 0; m_rd = 0; m_sel = '0; m_tc = 0;
        repeat (3) step();
        reset = 0;
        step();

        // single block
        n = put('0, 3, 4); r0 = n_reads;
        do_start(n, 3'd5); wait_idle(); repeat (3) step();
        chk("t1_reads", n_reads - r0, 4);
        chk("t1_done_lat", done_cyc - start_cyc, 5);

        // gaps skipped
        n = put(put(put('0, 0, 2), 7, 1), 19, 3); r0 = n_reads;
        do_start(n, 3'd2); wait_idle(); repeat (3) step();
        chk("t2_reads", n_reads - r0, 6);
        chk("t2_done_lat", done_cyc - start_cyc, 7);

        // budget
        n = '0;
        for (int b = 0; b < NBLK; b++) n = put(n, b, 63);
        r0 = n_reads; t0 = n_truncs; tc0 = m_tc;
        do_start(n, 3'd0); wait_idle(); repeat (3) step();
        chk("t3_reads", n_reads - r0, MAX_CYC);
        chk("t3_truncs", n_truncs - t0, 1);
        chk("t3_done_lat", done_cyc - start_cyc, MAX_CYC + 1);
`ifdef SEQ_TRUNC_CNT_EN
        chk("t3_trunc_cnt", trunc_cnt - 16'(tc0), 1152);
`endif

        // halt after second read
        n = put('0, 0, 5); r0 = n_reads;
        do_start(n, 3'd0); step(); step();
        halt = 1; repeat (3) step(); halt = 0;
        wait_idle(); repeat (3) step();
        chk("t4_reads", n_reads - r0, 5);
        chk("t4_done_lat", done_cyc - start_cyc, 9);

        // restart mid-event
        n = put('0, 0, 10); r0 = n_reads; d0 = n_dones;
        do_start(n, 3'd2); repeat (4) step();
        do_start(put('0, 1, 2), 3'd1); wait_idle(); repeat (3) step();
        chk("t5_dones", n_dones - d0, 1);
        chk("t5_reads", n_reads - r0, 6);
        chk("t5_done_lat", done_cyc - start_cyc, 3);

        // start coinciding with done
        d0 = n_dones;
        do_start(put('0, 3, 4), 3'd6); repeat (4) step();
        do_start(put('0, 2, 1), 3'd7); wait_idle(); repeat (3) step();
        chk("t7_dones", n_dones - d0, 2);

        // empty event
        r0 = n_reads;
        do_start('0, 3'd3); wait_idle(); repeat (3) step();
        chk("t6_reads", n_reads - r0, 0);
        chk("t6_done_lat", done_cyc - start_cyc, 1);

        // async reset mid-readout
        n = '0;
        for (int b = 0; b < NBLK; b++) n = put(n, b, 63);
        do_start(n, 3'd4); repeat (10) step();
        reset = 1;
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_read_add", read_add, 0);
        chk("rst_sel", sel, 0);
        chk("rst_dat_valid", dat_valid, 0);
        chk("rst_dat_sel", dat_sel, 0);
`ifdef SEQ_TRUNC_CNT_EN
        chk("rst_trunc_cnt", trunc_cnt, 0);
`endif
        step(); step();
        reset = 0;
        step();

        // randomized events with random halt and occasional restarts
        rand_halt = 1;
        for (int ev = 0; ev < 40; ev++) begin
            int prob;
            prob = ($urandom % 3 == 0) ? 5 : (($urandom % 2 == 0) ? 25 : 60);
            n = '0;
            for (int b = 0; b < NBLK; b++) begin
                if ($urandom % 100 < prob) n = put(n, b, ($urandom % 4 == 0) ? 63 : $urandom_range(1, 63));
            end
            do_start(n, BX_W'($urandom));
            if ($urandom % 4 == 0) repeat ($urandom_range(0, 30)) step();
            else wait_idle();
        end
        rand_halt = 0; halt = 0;
        wait_idle(); repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
